// File: rtl/scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scoreboard_pkg
// Description : Shared constants and types for the register scoreboard.
//               REG_ID_WIDTH / CNT_WIDTH are the default geometry, PEND_MAX
//               is the largest per-register pending count.
// Revision    : 1.0 - initial release
// ============================================================================
package scoreboard_pkg;

    localparam int REG_ID_WIDTH = 5;
    localparam int CNT_WIDTH    = 2;

    typedef logic [REG_ID_WIDTH-1:0] reg_id_t;
    typedef logic [CNT_WIDTH-1:0]    pend_cnt_t;

    localparam pend_cnt_t PEND_MAX = '1;

endpackage : scoreboard_pkg
`default_nettype wire

// File: rtl/scoreboard_entry.sv
`default_nettype none
// ============================================================================
// Module      : scoreboard_entry
// Description : Pending-writeback counter for one architectural register.
//   clk, reset : clock, synchronous active-high reset
//   inc        : an accepted issue targets this register
//   dec        : writeback to this register this cycle
//   flush      : clear the count at the next edge
//   count      : current pending count
//   busy       : count != 0
//   underflow  : pulse, writeback arrived while count was 0
// Revision    : 1.0 - initial release
// ============================================================================
module scoreboard_entry #(
    parameter int CNT_WIDTH = scoreboard_pkg::CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inc,
    input  logic                 dec,
    input  logic                 flush,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 busy,
    output logic                 underflow
);

    localparam logic [CNT_WIDTH-1:0] C_MAX = '1;

    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_d;

    // Simultaneous inc and dec cancel; the count never wraps in either
    // direction (issue is stalled at MAX, a stray dec at 0 is an error).
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (inc && !dec && (count_q != C_MAX)) begin
            count_d = count_q + 1'b1;
        end else if (dec && !inc && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count     = count_q;
    assign busy      = (count_q != '0);
    assign underflow = dec && !inc && !flush && (count_q == '0);

endmodule : scoreboard_entry
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : reg_scoreboard
// Description : Per-register pending-writeback scoreboard with RAW and
//               saturation stall for an in-order pipeline.
//   clk, reset           : clock, synchronous active-high reset
//   issue_*              : decode-stage instruction presented this cycle
//   issue_stall          : presented instruction must not issue
//   wb_reg_write/wb_dest : registered WB-stage write
//   flush                : discard all in-flight state
//   busy_vec             : per-register pending != 0
//   inflight_total       : sum of all pending counts
//   underflow_err        : sticky, writeback to a register with count 0
// Revision    : 1.0 - initial release
// ============================================================================
module reg_scoreboard #(
    parameter int REG_ID_WIDTH = scoreboard_pkg::REG_ID_WIDTH,
    parameter int NUM_REGS     = 1 << REG_ID_WIDTH,
    parameter int CNT_WIDTH    = scoreboard_pkg::CNT_WIDTH
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              issue_valid,
    input  logic                              issue_reg_write,
    input  logic [REG_ID_WIDTH-1:0]           issue_dest,
    input  logic                              issue_uses_rs1,
    input  logic                              issue_uses_rs2,
    input  logic [REG_ID_WIDTH-1:0]           issue_rs1,
    input  logic [REG_ID_WIDTH-1:0]           issue_rs2,
    output logic                              issue_stall,
    input  logic                              wb_reg_write,
    input  logic [REG_ID_WIDTH-1:0]           wb_dest,
    input  logic                              flush,
    output logic [NUM_REGS-1:0]               busy_vec,
    output logic [REG_ID_WIDTH+CNT_WIDTH-1:0] inflight_total,
    output logic                              underflow_err
);

    import scoreboard_pkg::*;

    localparam int                   TW    = REG_ID_WIDTH + CNT_WIDTH;
    localparam logic [CNT_WIDTH-1:0] C_MAX = '1;

    logic [CNT_WIDTH-1:0] w_count [NUM_REGS];
    logic [NUM_REGS-1:0]  w_busy;
    logic [NUM_REGS-1:0]  w_uflow;

    logic w_accept;
    logic w_inc_any;
    logic w_dec_any;
    logic w_same;
    logic w_inc_eff;
    logic w_dec_eff;

    logic [TW-1:0] total_q;
    logic [TW-1:0] total_d;
    logic          uerr_q;
    logic          uerr_d;

    // Register 0 is hardwired and never tracked.
    assign w_count[0] = '0;
    assign w_busy[0]  = 1'b0;
    assign w_uflow[0] = 1'b0;

    // Stall looks only at registered counts, so a writeback cannot unblock
    // a dependent instruction until the following cycle.
    assign issue_stall = issue_valid &&
                         ((issue_uses_rs1 && w_busy[issue_rs1]) ||
                          (issue_uses_rs2 && w_busy[issue_rs2]) ||
                          (issue_reg_write && (w_count[issue_dest] == C_MAX)));

    assign w_accept = issue_valid && !issue_stall;

    generate
        for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
            localparam logic [REG_ID_WIDTH-1:0] C_ID = REG_ID_WIDTH'(r);

            scoreboard_entry #(
                .CNT_WIDTH (CNT_WIDTH)
            ) u_entry (
                .clk       (clk),
                .reset     (reset),
                .inc       (w_accept && issue_reg_write && (issue_dest == C_ID)),
                .dec       (wb_reg_write && (wb_dest == C_ID)),
                .flush     (flush),
                .count     (w_count[r]),
                .busy      (w_busy[r]),
                .underflow (w_uflow[r])
            );
        end
    endgenerate

    // The total must stay equal to the sum of counts: an inc and dec on the
    // same register cancel, and a dec only counts if the entry was nonzero.
    assign w_inc_any = w_accept && issue_reg_write && (issue_dest != '0);
    assign w_dec_any = wb_reg_write && (wb_dest != '0);
    assign w_same    = w_inc_any && w_dec_any && (issue_dest == wb_dest);
    assign w_inc_eff = w_inc_any && !w_same;
    assign w_dec_eff = w_dec_any && !w_same && (w_count[wb_dest] != '0);

    always_comb begin
        total_d = total_q;
        uerr_d  = uerr_q;
        if (flush) begin
            total_d = '0;
        end else begin
            total_d = total_q + TW'(w_inc_eff) - TW'(w_dec_eff);
        end
        // Entry pulses are already masked by flush; the flag itself survives it.
        if (|w_uflow) begin
            uerr_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            total_q <= '0;
            uerr_q  <= 1'b0;
        end else begin
            total_q <= total_d;
            uerr_q  <= uerr_d;
        end
    end

    assign busy_vec       = w_busy;
    assign inflight_total = total_q;
    assign underflow_err  = uerr_q;

endmodule : reg_scoreboard
`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_scoreboard
// Description : Directed scoreboard bench for reg_scoreboard. Each stimulus
//               cycle queues the hand-computed expected state; a monitor
//               pops and compares entries on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_scoreboard;

    logic        clk;
    logic        reset;
    logic        issue_valid;
    logic        issue_reg_write;
    logic [4:0]  issue_dest;
    logic        issue_uses_rs1;
    logic        issue_uses_rs2;
    logic [4:0]  issue_rs1;
    logic [4:0]  issue_rs2;
    logic        issue_stall;
    logic        wb_reg_write;
    logic [4:0]  wb_dest;
    logic        flush;
    logic [31:0] busy_vec;
    logic [6:0]  inflight_total;
    logic        underflow_err;

    reg_scoreboard #(
        .REG_ID_WIDTH (5),
        .NUM_REGS     (32),
        .CNT_WIDTH    (2)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .issue_valid     (issue_valid),
        .issue_reg_write (issue_reg_write),
        .issue_dest      (issue_dest),
        .issue_uses_rs1  (issue_uses_rs1),
        .issue_uses_rs2  (issue_uses_rs2),
        .issue_rs1       (issue_rs1),
        .issue_rs2       (issue_rs2),
        .issue_stall     (issue_stall),
        .wb_reg_write    (wb_reg_write),
        .wb_dest         (wb_dest),
        .flush           (flush),
        .busy_vec        (busy_vec),
        .inflight_total  (inflight_total),
        .underflow_err   (underflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        string       name;
        logic        stall;
        logic [31:0] busy;
        logic [6:0]  total;
        logic        uerr;
    } exp_t;

    exp_t exp_q[$];
    int   cyc_cnt  = 0;
    int   n_cmp    = 0;
    int   n_fail   = 0;
    bit   stim_done = 1'b0;

    always @(posedge clk) cyc_cnt = cyc_cnt + 1;

    // Monitor: on each falling edge compare every expectation queued for
    // the current cycle (state after the last rising edge, current inputs).
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc == cyc_cnt) begin
            exp_t e;
            e = exp_q.pop_front();
            n_cmp++;
            if (issue_stall !== e.stall) begin
                n_fail++;
                $display("FAIL %s.stall: got %0b expected %0b", e.name, issue_stall, e.stall);
            end
            n_cmp++;
            if (busy_vec !== e.busy) begin
                n_fail++;
                $display("FAIL %s.busy_vec: got %h expected %h", e.name, busy_vec, e.busy);
            end
            n_cmp++;
            if (inflight_total !== e.total) begin
                n_fail++;
                $display("FAIL %s.inflight_total: got %0d expected %0d", e.name, inflight_total, e.total);
            end
            n_cmp++;
            if (underflow_err !== e.uerr) begin
                n_fail++;
                $display("FAIL %s.underflow_err: got %0b expected %0b", e.name, underflow_err, e.uerr);
            end
        end
        if (exp_q.size() > 0 && exp_q[0].cyc < cyc_cnt) begin
            exp_t s;
            s = exp_q.pop_front();
            n_cmp++;
            n_fail++;
            $display("FAIL %s.stale: queued for cycle %0d, monitor at %0d", s.name, s.cyc, cyc_cnt);
        end
    end

    // Drive one cycle of inputs just after the rising edge.
    task automatic drive(input logic rst, input logic iv, input logic irw, input logic [4:0] idst,
                         input logic u1, input logic [4:0] r1, input logic u2, input logic [4:0] r2,
                         input logic wbw, input logic [4:0] wbd, input logic fl);
        @(posedge clk);
        #1;
        reset           = rst;
        issue_valid     = iv;
        issue_reg_write = irw;
        issue_dest      = idst;
        issue_uses_rs1  = u1;
        issue_rs1       = r1;
        issue_uses_rs2  = u2;
        issue_rs2       = r2;
        wb_reg_write    = wbw;
        wb_dest         = wbd;
        flush           = fl;
    endtask

    task automatic expect_now(input string nm, input logic st, input logic [31:0] bz,
                              input logic [6:0] tot, input logic ue);
        exp_t e;
        e.cyc   = cyc_cnt;
        e.name  = nm;
        e.stall = st;
        e.busy  = bz;
        e.total = tot;
        e.uerr  = ue;
        exp_q.push_back(e);
    endtask

    // Shorthands: idle cycle, issue-with-dest, writeback
    task automatic idle(input logic rst);
        drive(rst, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0);
    endtask

    task automatic iss(input logic [4:0] d, input logic wbw, input logic [4:0] wbd, input logic fl);
        drive(0, 1, 1, d, 0, 5'd0, 0, 5'd0, wbw, wbd, fl);
    endtask

    initial begin
        reset = 1'b1; issue_valid = 0; issue_reg_write = 0; issue_dest = '0;
        issue_uses_rs1 = 0; issue_uses_rs2 = 0; issue_rs1 = '0; issue_rs2 = '0;
        wb_reg_write = 0; wb_dest = '0; flush = 0;
        repeat (3) idle(1);

        idle(0);                         expect_now("reset_state",   0, 32'h0,  7'd0, 0);
        iss(5'd5, 0, 5'd0, 0);           expect_now("issue_d5",      0, 32'h0,  7'd0, 0);
        drive(0, 1, 0, 5'd0, 1, 5'd5, 0, 5'd0, 0, 5'd0, 0);
                                         expect_now("raw_rs1_5",     1, 32'h20, 7'd1, 0);
        drive(0, 1, 0, 5'd0, 0, 5'd0, 1, 5'd5, 1, 5'd5, 0);
                                         expect_now("raw_rs2_wb_N",  1, 32'h20, 7'd1, 0);
        drive(0, 1, 0, 5'd0, 0, 5'd0, 1, 5'd5, 0, 5'd0, 0);
                                         expect_now("raw_rs2_N1",    0, 32'h0,  7'd0, 0);

        // Fill r7 to saturation.
        iss(5'd7, 0, 5'd0, 0);           expect_now("d7_1",          0, 32'h0,  7'd0, 0);
        iss(5'd7, 0, 5'd0, 0);           expect_now("d7_2",          0, 32'h80, 7'd1, 0);
        iss(5'd7, 0, 5'd0, 0);           expect_now("d7_3",          0, 32'h80, 7'd2, 0);
        iss(5'd7, 0, 5'd0, 0);           expect_now("d7_4_sat",      1, 32'h80, 7'd3, 0);
        // At MAX the issue is stalled, so only the writeback lands: 3 -> 2.
        iss(5'd7, 1, 5'd7, 0);           expect_now("d7_sat_wb",     1, 32'h80, 7'd3, 0);
        // Below MAX, issue and writeback to r7 together cancel: stays 2.
        iss(5'd7, 1, 5'd7, 0);           expect_now("d7_inc_dec",    0, 32'h80, 7'd2, 0);
        iss(5'd7, 0, 5'd0, 0);           expect_now("d7_after_cancel", 0, 32'h80, 7'd2, 0);
        iss(5'd7, 0, 5'd0, 0);           expect_now("d7_resat",      1, 32'h80, 7'd3, 0);
        drive(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 5'd7, 0);
                                         expect_now("wb7_a",         0, 32'h80, 7'd3, 0);
        drive(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 5'd7, 0);
                                         expect_now("wb7_b",         0, 32'h80, 7'd2, 0);
        drive(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 5'd7, 0);
                                         expect_now("wb7_c",         0, 32'h80, 7'd1, 0);

        // Register 0: never tracked, never busy, no underflow.
        drive(0, 1, 1, 5'd0, 1, 5'd0, 0, 5'd0, 1, 5'd0, 0);
                                         expect_now("r0_issue_wb",   0, 32'h0,  7'd0, 0);
        idle(0);                         expect_now("r0_after",      0, 32'h0,  7'd0, 0);

        // Underflow on r9.
        drive(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 5'd9, 0);
                                         expect_now("uf_wb9",        0, 32'h0,  7'd0, 0);
        idle(0);                         expect_now("uf_set",        0, 32'h0,  7'd0, 1);

        // Four registers pending, then flush alongside an issue to r3.
        iss(5'd1, 0, 5'd0, 0);           expect_now("fill_1",        0, 32'h0,  7'd0, 1);
        iss(5'd2, 0, 5'd0, 0);           expect_now("fill_2",        0, 32'h2,  7'd1, 1);
        iss(5'd3, 0, 5'd0, 0);           expect_now("fill_3",        0, 32'h6,  7'd2, 1);
        iss(5'd4, 0, 5'd0, 0);           expect_now("fill_4",        0, 32'hE,  7'd3, 1);
        iss(5'd3, 0, 5'd0, 1);           expect_now("flush_cycle",   0, 32'h1E, 7'd4, 1);
        idle(0);                         expect_now("post_flush",    0, 32'h0,  7'd0, 1);

        // Reset overrides a concurrent issue and clears the sticky flag.
        drive(1, 1, 1, 5'd6, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0);
                                         expect_now("rst_cycle",     0, 32'h0,  7'd0, 1);
        idle(0);                         expect_now("post_reset",    0, 32'h0,  7'd0, 0);

        repeat (3) idle(0);
        stim_done = 1'b1;
    end

    initial begin : finisher
        int guard;
        guard = 0;
        while (!stim_done && guard < 5000) begin
            @(posedge clk);
            guard++;
        end
        if (!stim_done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL timeout: stimulus did not complete within %0d cycles", guard);
        end
        @(posedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_reg_scoreboard
`default_nettype wire
